cue_driver: RTL and testbench

//  Output-side counterpart to the push-button debouncer. It takes a one-cycle

---
 rtl/cue_driver.sv | 188 ++++++++++++++++++
 tb/tb_cue_driver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cue_driver.sv
// cue_driver: turns a one-cycle request pulse into a timed, human-visible cue.
// A one-hot LED/tone channel is lit for a programmable number of milliseconds.
// A fixed dark gap follows, and then a one-cycle done pulse.
// All outputs are registered; timing is derived from a ms prescaler plus a
// down-counting ms counter that is reloaded on every state entry.
module cue_driver #(
    parameter int TICK_DIV = 49999,
    parameter int GAP_MS   = 100,
    parameter int N_CH     = 4,
    parameter int CH_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   channel,
    input  logic [9:0]        dur_ms,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   led,
    output logic              tone_en,
    output logic [CH_W-1:0]   tone_sel
);

    // Prescaler width; a divider of 0 still needs a one-bit counter.
    localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV);
    localparam logic          HAS_GAP  = (GAP_MS > 0);
    // The ms counter counts down to zero, so it is loaded with length-1.
    localparam logic [9:0]    GAP_LOAD = (GAP_MS > 0) ? 10'(GAP_MS - 1) : 10'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_r, state_next;
    logic [PW-1:0]     presc_r, presc_next;
    logic [9:0]        ms_r, ms_next;
    logic              busy_r, busy_next;
    logic              done_r, done_next;
    logic [N_CH-1:0]   led_r, led_next;
    logic              tone_en_r, tone_en_next;
    logic [CH_W-1:0]   tone_sel_r, tone_sel_next;

    logic              tick_s;
    logic [N_CH-1:0]   onehot_s;
    logic [9:0]        dur_load_s;

    assign tick_s     = (presc_r == PRESC_TC);
    // A zero duration is treated as one ms.
    assign dur_load_s = (dur_ms == 10'd0) ? 10'd0 : (dur_ms - 10'd1);

    // Decode the requested channel; out-of-range indices light nothing.
    always_comb begin
        onehot_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (channel == CH_W'(i)) begin
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // Next-state, counter and output logic; every path starts from hold values.
    always_comb begin
        state_next    = state_r;
        presc_next    = presc_r;
        ms_next       = ms_r;
        busy_next     = busy_r;
        done_next     = 1'b0;
        led_next      = led_r;
        tone_en_next  = tone_en_r;
        tone_sel_next = tone_sel_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    // Acceptance wins over a simultaneous abort.
                    state_next    = ON;
                    presc_next    = {PW{1'b0}};
                    ms_next       = dur_load_s;
                    busy_next     = 1'b1;
                    led_next      = onehot_s;
                    tone_en_next  = |onehot_s;
                    tone_sel_next = channel;
                end else begin
                    busy_next    = 1'b0;
                    led_next     = {N_CH{1'b0}};
                    tone_en_next = 1'b0;
                end
            end

            ON: begin
                if (abort) begin
                    state_next   = IDLE;
                    presc_next   = {PW{1'b0}};
                    ms_next      = 10'd0;
                    busy_next    = 1'b0;
                    led_next     = {N_CH{1'b0}};
                    tone_en_next = 1'b0;
                end else if (tick_s) begin
                    presc_next = {PW{1'b0}};
                    if (ms_r == 10'd0) begin
                        led_next     = {N_CH{1'b0}};
                        tone_en_next = 1'b0;
                        if (HAS_GAP) begin
                            state_next = GAP;
                            ms_next    = GAP_LOAD;
                        end else begin
                            state_next = IDLE;
                            ms_next    = 10'd0;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end else begin
                        ms_next = ms_r - 10'd1;
                    end
                end else begin
                    presc_next = presc_r + PW'(1);
                end
            end

            GAP: begin
                if (abort) begin
                    state_next   = IDLE;
                    presc_next   = {PW{1'b0}};
                    ms_next      = 10'd0;
                    busy_next    = 1'b0;
                    led_next     = {N_CH{1'b0}};
                    tone_en_next = 1'b0;
                end else if (tick_s) begin
                    presc_next = {PW{1'b0}};
                    if (ms_r == 10'd0) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        ms_next = ms_r - 10'd1;
                    end
                end else begin
                    presc_next = presc_r + PW'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                presc_next   = {PW{1'b0}};
                ms_next      = 10'd0;
                busy_next    = 1'b0;
                led_next     = {N_CH{1'b0}};
                tone_en_next = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            presc_r    <= {PW{1'b0}};
            ms_r       <= 10'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            led_r      <= {N_CH{1'b0}};
            tone_en_r  <= 1'b0;
            tone_sel_r <= {CH_W{1'b0}};
        end else begin
            state_r    <= state_next;
            presc_r    <= presc_next;
            ms_r       <= ms_next;
            busy_r     <= busy_next;
            done_r     <= done_next;
            led_r      <= led_next;
            tone_en_r  <= tone_en_next;
            tone_sel_r <= tone_sel_next;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign led      = led_r;
    assign tone_en  = tone_en_r;
    assign tone_sel = tone_sel_r;

endmodule

// File: tb/tb_cue_driver.sv
// Directed testbench for cue_driver with a 4-cycle ms and a 2 ms gap.
module tb_cue_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] channel;
    logic [9:0] dur_ms;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] led;
    logic       tone_en;
    logic [1:0] tone_sel;

    int checks = 0;
    int errors = 0;

    localparam int CLK_PER_MS = 4;
    localparam int GAP_CYC    = 8;

    cue_driver #(
        .TICK_DIV (3),
        .GAP_MS   (2),
        .N_CH     (4),
        .CH_W     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .channel  (channel),
        .dur_ms   (dur_ms),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .led      (led),
        .tone_en  (tone_en),
        .tone_sel (tone_sel)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int k,
                         input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s k=%0d observed %0h expected %0h", tag, k, obs, exp_v);
        end
    endtask

    // Issue one cue and follow it cycle by cycle up to its done cycle.
    // inj_at: cycle at which a second start (ch 1, dur 7) is offered; -1 none.
    // abort_at: cycle at which abort is raised; -1 none.
    // ab0: raise abort together with the accepted start.
    task automatic cue(input logic [1:0] ch, input logic [9:0] dur,
                       input int inj_at, input int abort_at, input bit ab0);
        int         d;
        int         on_len;
        int         last;
        logic [3:0] exp_led;
        bit         aborted;
        d       = (dur == 10'd0) ? 1 : int'(dur);
        on_len  = d * CLK_PER_MS;
        last    = on_len + GAP_CYC + 1;
        exp_led = 4'b0001 << ch;
        start   = 1'b1;
        channel = ch;
        dur_ms  = dur;
        abort   = ab0;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= last; k++) begin
            aborted = (abort_at >= 0) && (k > abort_at);
            if (aborted) begin
                check("led_abort",  k, 16'(led),  16'h0);
                check("busy_abort", k, 16'(busy), 16'h0);
                check("done_abort", k, 16'(done), 16'h0);
                check("tone_abort", k, 16'(tone_en), 16'h0);
            end else begin
                check("led",  k, 16'(led),  (k <= on_len) ? 16'(exp_led) : 16'h0);
                check("busy", k, 16'(busy), (k <= on_len + GAP_CYC) ? 16'h1 : 16'h0);
                check("done", k, 16'(done), (k == last) ? 16'h1 : 16'h0);
                check("tone_en", k, 16'(tone_en), (k <= on_len) ? 16'h1 : 16'h0);
            end
            check("tone_sel", k, 16'(tone_sel), 16'(ch));
            if (k < last) begin
                start = (k == inj_at);
                if (k == inj_at) begin
                    channel = 2'd1;
                    dur_ms  = 10'd7;
                end
                abort = (k == abort_at);
                step();
                start = 1'b0;
                abort = 1'b0;
            end
        end
    endtask

    initial begin
        // Case 1: reset held 3 cycles with start asserted.
        reset   = 1'b1;
        start   = 1'b1;
        channel = 2'd2;
        dur_ms  = 10'd3;
        abort   = 1'b0;
        step();
        step();
        step();
        check("rst_busy",     0, 16'(busy),     16'h0);
        check("rst_done",     0, 16'(done),     16'h0);
        check("rst_led",      0, 16'(led),      16'h0);
        check("rst_tone_en",  0, 16'(tone_en),  16'h0);
        check("rst_tone_sel", 0, 16'(tone_sel), 16'h0);
        reset = 1'b0;
        start = 1'b0;
        step();
        step();
        check("idle_busy", 0, 16'(busy), 16'h0);
        check("idle_led",  0, 16'(led),  16'h0);

        // Case 2: channel 2 for 3 ms.
        cue(2'd2, 10'd3, -1, -1, 1'b0);
        step();

        // Case 3: start for channel 1 at t+5 must be ignored.
        cue(2'd2, 10'd3, 5, -1, 1'b0);
        step();

        // Case 4: abort at t+6.
        cue(2'd2, 10'd3, -1, 6, 1'b0);

        // Case 5: zero duration on channel 0, abort offered with the start.
        cue(2'd0, 10'd0, -1, -1, 1'b1);

        // Case 6: start channel 3 in the done cycle runs back to back.
        cue(2'd3, 10'd2, -1, -1, 1'b0);

        // Reset in the middle of the gap.
        start   = 1'b1;
        channel = 2'd1;
        dur_ms  = 10'd1;
        step();
        start = 1'b0;
        check("b2b_led", 1, 16'(led), 16'h2);
        for (int i = 0; i < 4 + 2; i++) step();
        check("gap_busy", 7, 16'(busy), 16'h1);
        check("gap_led",  7, 16'(led),  16'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy",     0, 16'(busy),     16'h0);
        check("mid_rst_done",     0, 16'(done),     16'h0);
        check("mid_rst_led",      0, 16'(led),      16'h0);
        check("mid_rst_tone_en",  0, 16'(tone_en),  16'h0);
        check("mid_rst_tone_sel", 0, 16'(tone_sel), 16'h0);
        for (int i = 1; i <= 10; i++) begin
            step();
            check("post_rst_done", i, 16'(done), 16'h0);
            check("post_rst_busy", i, 16'(busy), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
